// File: rtl/id_ex.sv
// ID->EX pipeline register with a valid/ready handshake, 2-entry skid buffer and flush.
// Optional ID_EX_PERF_EN adds stall/bubble performance counters.
module id_ex #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter logic [31:0] NOP_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] inst_i,
  input  logic [31:0] instaddr_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        regs_wen_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        id_valid_i,
  output logic        id_ready_o,
  input  logic        flush_i,
  output logic [31:0] inst_o,
  output logic [31:0] instaddr_o,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o,
  output logic        regs_wen_o,
  output logic [4:0]  rd_addr_o,
  output logic        ex_valid_o,
  input  logic        ex_ready_i
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] instaddr;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        regs_wen;
    logic [4:0]  rd_addr;
  } payload_t;

  // Empty slots hold NOP fields, so regs_wen/rd_addr are already zero when invalid.
  localparam payload_t NOP_PAYLOAD = '{
    inst:     NOP_INST,
    instaddr: NOP_ADDR,
    op1:      32'd0,
    op2:      32'd0,
    regs_wen: 1'b0,
    rd_addr:  5'd0
  };

  state_e   state_q, state_d;
  payload_t main_q, main_d;
  payload_t skid_q, skid_d;
  logic     ready_q, ready_d;
  logic     valid_q, valid_d;
  payload_t in_pl_s;
  logic     in_s;
  logic     out_s;

  assign in_pl_s = '{
    inst:     inst_i,
    instaddr: instaddr_i,
    op1:      op1_i,
    op2:      op2_i,
    regs_wen: regs_wen_i,
    rd_addr:  rd_addr_i
  };

  assign in_s  = id_valid_i & ready_q;
  assign out_s = valid_q & ex_ready_i;

  // Next-state and storage update; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = S_EMPTY;
      main_d  = NOP_PAYLOAD;
      skid_d  = NOP_PAYLOAD;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_s) begin
            state_d = S_BUSY;
            main_d  = in_pl_s;
          end else begin
            state_d = S_EMPTY;
          end
        end
        S_BUSY: begin
          if (in_s && out_s) begin
            main_d = in_pl_s;
          end else if (in_s) begin
            state_d = S_FULL;
            skid_d  = in_pl_s;
          end else if (out_s) begin
            state_d = S_EMPTY;
            main_d  = NOP_PAYLOAD;
          end else begin
            state_d = S_BUSY;
          end
        end
        S_FULL: begin
          if (out_s) begin
            state_d = S_BUSY;
            main_d  = skid_q;
            skid_d  = NOP_PAYLOAD;
          end else begin
            state_d = S_FULL;
          end
        end
        default: begin
          state_d = S_EMPTY;
          main_d  = NOP_PAYLOAD;
          skid_d  = NOP_PAYLOAD;
        end
      endcase
    end
    ready_d = (state_d != S_FULL);
    valid_d = (state_d != S_EMPTY);
  end

  // State, payload and handshake flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_EMPTY;
      main_q  <= NOP_PAYLOAD;
      skid_q  <= NOP_PAYLOAD;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign id_ready_o = ready_q;
  assign ex_valid_o = valid_q;
  assign inst_o     = main_q.inst;
  assign instaddr_o = main_q.instaddr;
  assign op1_o      = main_q.op1;
  assign op2_o      = main_q.op2;
  assign regs_wen_o = main_q.regs_wen;
  assign rd_addr_o  = main_q.rd_addr;

`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] bubble_cnt_q;

  // Free-running counters; flush does not clear them and they wrap naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (id_valid_i && !ready_q) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (!valid_q) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end else begin
        bubble_cnt_q <= bubble_cnt_q;
      end
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex.sv
// Scoreboard bench for id_ex: a capacity-2 FIFO reference model feeds an expected queue
// that a negedge monitor checks against the DUT outputs.
module tb_id_ex;

  typedef logic [133:0] pl_t;

  localparam logic [31:0] NOP_INST_TB = 32'h0000_0013;
  localparam pl_t NOP_PL = {NOP_INST_TB, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0};

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] inst_i, instaddr_i, op1_i, op2_i;
  logic        regs_wen_i;
  logic [4:0]  rd_addr_i;
  logic        id_valid_i, id_ready_o, flush_i;
  logic [31:0] inst_o, instaddr_o, op1_o, op2_o;
  logic        regs_wen_o;
  logic [4:0]  rd_addr_o;
  logic        ex_valid_o, ex_ready_i;
`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt_o, bubble_cnt_o;
  logic [31:0] m_stall, m_bubble;
`endif

  pl_t exp_q[$];
  int  model_cnt;
  int  n_checks;
  int  n_fail;
  pl_t dut_pl;
  logic acc;

  assign dut_pl = {inst_o, instaddr_o, op1_o, op2_o, regs_wen_o, rd_addr_o};

  id_ex dut (
    .clk(clk), .rstn(rstn),
    .inst_i(inst_i), .instaddr_i(instaddr_i), .op1_i(op1_i), .op2_i(op2_i),
    .regs_wen_i(regs_wen_i), .rd_addr_i(rd_addr_i),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .flush_i(flush_i),
    .inst_o(inst_o), .instaddr_o(instaddr_o), .op1_o(op1_o), .op2_o(op2_o),
    .regs_wen_o(regs_wen_o), .rd_addr_o(rd_addr_o),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i)
`ifdef ID_EX_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input pl_t act, input pl_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic pl_t rand_pl();
    pl_t p;
    p = {$urandom, $urandom, $urandom, $urandom, 1'($urandom), 5'($urandom)};
    return p;
  endfunction

  // Drive one cycle; at the edge the reference model (a FIFO of depth 2) is advanced.
  task automatic apply(input logic v, input pl_t p, input logic rdy, input logic fl,
                       output logic accepted);
    logic in_ok, out_ok;
    id_valid_i = v;
    {inst_i, instaddr_i, op1_i, op2_i, regs_wen_i, rd_addr_i} = p;
    ex_ready_i = rdy;
    flush_i    = fl;
    @(posedge clk);
    in_ok  = v && (model_cnt < 2);
    out_ok = (model_cnt > 0) && rdy;
    accepted = 1'b0;
    if (rstn) begin
`ifdef ID_EX_PERF_EN
      if (v && model_cnt == 2) m_stall = m_stall + 32'd1;
      if (model_cnt == 0) m_bubble = m_bubble + 32'd1;
`endif
      if (fl) begin
        exp_q.delete();
        model_cnt = 0;
      end else begin
        if (out_ok) model_cnt--;
        if (in_ok) begin
          model_cnt++;
          exp_q.push_back(p);
          accepted = 1'b1;
        end
      end
    end
    #1;
  endtask

  // Monitor: compare presented payload with the head of the expected queue.
  always @(negedge clk) begin
    check("id_ready", pl_t'(id_ready_o), pl_t'(model_cnt < 2));
    check("ex_valid", pl_t'(ex_valid_o), pl_t'(model_cnt > 0));
`ifdef ID_EX_PERF_EN
    check("stall_cnt", pl_t'(stall_cnt_o), pl_t'(m_stall));
    check("bubble_cnt", pl_t'(bubble_cnt_o), pl_t'(m_bubble));
`endif
    if (ex_valid_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL payload_underflow: got %h expected none", dut_pl);
      end else begin
        check("payload", dut_pl, exp_q[0]);
        if (ex_ready_i) void'(exp_q.pop_front());
      end
    end else begin
      check("empty_payload", dut_pl, NOP_PL);
    end
  end

  initial begin
    pl_t pa, pb, pc;
    n_checks = 0;
    n_fail = 0;
    model_cnt = 0;
`ifdef ID_EX_PERF_EN
    m_stall = 32'd0;
    m_bubble = 32'd0;
`endif
    rstn = 1'b0;
    id_valid_i = 1'b0;
    ex_ready_i = 1'b0;
    flush_i = 1'b0;
    {inst_i, instaddr_i, op1_i, op2_i, regs_wen_i, rd_addr_i} = '0;

    // Reset with random inputs
    for (int i = 0; i < 4; i++) apply(1'($urandom), rand_pl(), 1'($urandom), 1'b0, acc);
    check("reset_inst", pl_t'(inst_o), pl_t'(NOP_INST_TB));
    rstn = 1'b1;
    for (int i = 0; i < 2; i++) apply(1'b0, rand_pl(), 1'b1, 1'b0, acc);

    // Streaming back-to-back
    pa = {32'h00500093, 32'h0000_0000, 32'd0, 32'd5, 1'b1, 5'd1};
    pb = {32'h00a00113, 32'h0000_0004, 32'd0, 32'd10, 1'b1, 5'd2};
    apply(1'b1, pa, 1'b1, 1'b0, acc);
    check("stream_rd1", pl_t'(rd_addr_o), pl_t'(5'd1));
    apply(1'b1, pb, 1'b1, 1'b0, acc);
    check("stream_rd2", pl_t'(rd_addr_o), pl_t'(5'd2));
    check("stream_wen", pl_t'(regs_wen_o), pl_t'(1'b1));
    for (int i = 0; i < 2; i++) apply(1'b0, rand_pl(), 1'b1, 1'b0, acc);

    // Backpressure A,B,C then release
    pa = rand_pl(); pb = rand_pl(); pc = rand_pl();
    apply(1'b1, pa, 1'b0, 1'b0, acc);
    apply(1'b1, pb, 1'b0, 1'b0, acc);
    apply(1'b1, pc, 1'b0, 1'b0, acc);
    check("bp_ready_low", pl_t'(id_ready_o), pl_t'(1'b0));
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) apply(1'b1, pc, 1'b1, 1'b0, acc);
    check("bp_c_accepted", pl_t'(acc), pl_t'(1'b1));
    for (int i = 0; i < 4; i++) apply(1'b0, rand_pl(), 1'b1, 1'b0, acc);
    check("bp_drained", pl_t'(exp_q.size()), pl_t'(0));

    // Flush while FULL with a concurrent payload
    apply(1'b1, rand_pl(), 1'b0, 1'b0, acc);
    apply(1'b1, rand_pl(), 1'b0, 1'b0, acc);
    apply(1'b1, rand_pl(), 1'b1, 1'b1, acc);
    check("flush_valid", pl_t'(ex_valid_o), pl_t'(1'b0));
    check("flush_payload", dut_pl, NOP_PL);
    check("flush_ready", pl_t'(id_ready_o), pl_t'(1'b1));
    apply(1'b0, rand_pl(), 1'b1, 1'b0, acc);

    // Async reset between edges while FULL
    apply(1'b1, rand_pl(), 1'b0, 1'b0, acc);
    apply(1'b1, rand_pl(), 1'b0, 1'b0, acc);
    #2;
    rstn = 1'b0;
    #1;
    check("areset_valid", pl_t'(ex_valid_o), pl_t'(1'b0));
    check("areset_ready", pl_t'(id_ready_o), pl_t'(1'b1));
    check("areset_payload", dut_pl, NOP_PL);
    exp_q.delete();
    model_cnt = 0;
`ifdef ID_EX_PERF_EN
    m_stall = 32'd0;
    m_bubble = 32'd0;
`endif
    for (int i = 0; i < 2; i++) apply(1'($urandom), rand_pl(), 1'($urandom), 1'b0, acc);
    rstn = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 9) < 7), rand_pl(), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 19) == 0), acc);
    end

    for (int i = 0; i < 4; i++) apply(1'b0, rand_pl(), 1'b1, 1'b0, acc);
    check("final_drained", pl_t'(exp_q.size()), pl_t'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex.md
Name: id_ex

Overview:
- Pipeline stage between instruction decode and execute.
- Registers the decoded payload: inst, instaddr, op1, op2, regs_wen, rd_addr.
- Uses a valid/ready handshake with a 2-entry skid buffer, so id_ready_o is a pure register output and no combinational ready path runs from EX back into ID.
- Supports synchronous flush, which inserts a bubble (NOP) for branch/jump redirect.

Parameters:
- NOP_INST, 32'h0000_0013, instruction presented when stage empty/reset/flushed (addi x0,x0,0).
- NOP_ADDR, 32'h0000_0000, instaddr presented when stage empty/reset/flushed.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- inst_i  input  32  decoded instruction from id.
- instaddr_i  input  32  instruction address from id.
- op1_i  input  32  operand 1 from id.
- op2_i  input  32  operand 2 from id.
- regs_wen_i  input  1  register write enable from id.
- rd_addr_i  input  5  destination register from id.
- id_valid_i  input  1  id payload valid.
- id_ready_o  output  1  stage can accept; registered.
- flush_i  input  1  synchronous flush, highest priority.
- inst_o  output  32  instruction to ex.
- instaddr_o  output  32  address to ex.
- op1_o  output  32  operand 1 to ex.
- op2_o  output  32  operand 2 to ex.
- regs_wen_o  output  1  write enable to ex; 0 whenever ex_valid_o=0.
- rd_addr_o  output  5  destination register to ex; 0 when ex_valid_o=0.
- ex_valid_o  output  1  payload valid to ex.
- ex_ready_i  input  1  ex accepts payload this cycle.

Behaviour:
- Reset: rstn async active-low, on clk domain. While rstn=0:
  - state=EMPTY, id_ready_o=1, ex_valid_o=0;
  - inst_o=NOP_INST, instaddr_o=NOP_ADDR, op1_o=op2_o=0, regs_wen_o=0, rd_addr_o=0.
- Storage: main register (drives outputs) and skid register.
- Per-cycle events:
  - in = id_valid_i & id_ready_o
  - out = ex_valid_o & ex_ready_i
- FSM, 3 states:
  - EMPTY (main invalid):
    - in -> BUSY, main<=input.
  - BUSY (main valid, skid empty):
    - in&out -> BUSY, main<=input.
    - in&!out -> FULL, skid<=input, main holds.
    - !in&out -> EMPTY, main<=NOP fields.
    - neither -> hold.
  - FULL (both valid):
    - in impossible (id_ready_o=0).
    - out -> BUSY, main<=skid.
    - else hold.
- id_ready_o = (state!=FULL), from state register. ex_valid_o = (state!=EMPTY).
- Latency: payload accepted at edge N is visible on outputs after edge N, provided main was empty or drained at N.
- Ordering is strict FIFO; no payload is dropped or duplicated.
- Payload stability: outputs stay stable while ex_valid_o=1 and ex_ready_i=0.
- Flush: flush_i=1 at an edge forces state=EMPTY and main/skid to NOP fields.
  - Any simultaneous in/out is discarded; flush wins over all.
  - id_ready_o=1 after the flush edge.
- Empty outputs: regs_wen_o and rd_addr_o are gated to 0 when the stage is empty, so no spurious register write occurs.
- No arithmetic on payload; widths pass through unchanged.

Optional Feature:
- Macro ID_EX_PERF_EN.
- Defined: adds output ports stall_cnt_o (32) and bubble_cnt_o (32).
  - stall_cnt_o counts cycles with id_valid_i=1 & id_ready_o=0.
  - bubble_cnt_o counts cycles with ex_valid_o=0.
  - Both reset to 0 on rstn, are not cleared by flush, and wrap 32'hFFFF_FFFF -> 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset: hold rstn=0 with random inputs -> ex_valid_o=0, inst_o=32'h13, regs_wen_o=0, id_ready_o=1; release -> unchanged until id_valid_i.
- Streaming: ex_ready_i=1, id sends inst 32'h00500093 @0x0 then 32'h00a00113 @0x4 back-to-back -> each appears one cycle after acceptance, regs_wen_o=1, rd_addr_o=1 then 2, id_ready_o stays 1.
- Backpressure: ex_ready_i=0 with three valid payloads A,B,C -> A on outputs, B in skid, id_ready_o=0, C held by id; release ex_ready_i -> A,B,C delivered in order, none lost.
- Flush while FULL, with simultaneous id_valid_i=1 -> next cycle ex_valid_o=0, inst_o=32'h13, regs_wen_o=0, id_ready_o=1; the concurrent payload is not captured.
- Async reset mid-operation: rstn=0 between edges while FULL -> outputs go to reset values immediately, not at the next edge.
- With ID_EX_PERF_EN: 5 cycles of backpressure with id_valid_i=1 and 2 idle cycles -> stall_cnt_o=3 (cycles after skid fills), bubble_cnt_o=2 plus the initial empty cycles; counter preset near 32'hFFFF_FFFF wraps to 0.
